// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: instruction field layout, opcode and
// ALU encodings, the decoded control word and the opcode decode table.
package decode_stage_pkg;

  // Instruction layout: [31:27] opcode, [24:20] dest, [19:15] srcA, [14:10] srcB.
  // Register fields are 5 bits wide; the design uses the low REG_W bits of each.
  localparam int OPC_W    = 5;
  localparam int OPC_LSB  = 27;
  localparam int DEST_LSB = 20;
  localparam int SRCA_LSB = 15;
  localparam int SRCB_LSB = 10;

  localparam logic [OPC_W-1:0] OP_ADD = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 5'd1;
  localparam logic [OPC_W-1:0] OP_AND = 5'd2;
  localparam logic [OPC_W-1:0] OP_ORR = 5'd3;
  localparam logic [OPC_W-1:0] OP_NOR = 5'd4;
  localparam logic [OPC_W-1:0] OP_XOR = 5'd5;
  localparam logic [OPC_W-1:0] OP_LSL = 5'd6;
  localparam logic [OPC_W-1:0] OP_LSR = 5'd7;
  localparam logic [OPC_W-1:0] OP_LDW = 5'd8;
  localparam logic [OPC_W-1:0] OP_LDB = 5'd9;
  localparam logic [OPC_W-1:0] OP_STW = 5'd10;
  localparam logic [OPC_W-1:0] OP_STB = 5'd11;
  localparam logic [OPC_W-1:0] OP_BNE = 5'd12;
  localparam logic [OPC_W-1:0] OP_BLT = 5'd13;
  localparam logic [OPC_W-1:0] OP_BST = 5'd14;
  localparam logic [OPC_W-1:0] OP_MOV = 5'd15;
  localparam logic [OPC_W-1:0] OP_NOP = 5'd16;

  // ALU codes for the register-register group equal the low bits of their opcode.
  localparam int ALU_W = 4;
  localparam logic [ALU_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_W-1:0] ALU_ORR   = 4'd3;
  localparam logic [ALU_W-1:0] ALU_NOR   = 4'd4;
  localparam logic [ALU_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALU_W-1:0] ALU_LSL   = 4'd6;
  localparam logic [ALU_W-1:0] ALU_LSR   = 4'd7;
  localparam logic [ALU_W-1:0] ALU_LT    = 4'd8;
  localparam logic [ALU_W-1:0] ALU_PASSA = 4'd9;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic             regWrEn;
    logic             memEn;
    logic             memRW;
    logic             is_branch;
    logic             SEL_valB;
    logic             SEL_wrData;
    logic             SEL_destReg;
    logic             useSrcA;
    logic             useSrcB;
    logic [ALU_W-1:0] alu_op;
  } control_t;

  function automatic control_t decodeOp(input logic [OPC_W-1:0] opc);
    control_t c;
    c = '0;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_NOR, OP_XOR, OP_LSL, OP_LSR: begin
        c.regWrEn = 1'b1;
        c.alu_op  = opc[ALU_W-1:0];
        c.useSrcA = 1'b1;
        c.useSrcB = 1'b1;
      end
      OP_LDW, OP_LDB: begin
        c.regWrEn     = 1'b1;
        c.memEn       = 1'b1;
        c.SEL_valB    = 1'b1;
        c.SEL_wrData  = 1'b1;
        c.SEL_destReg = 1'b1;
        c.alu_op      = ALU_ADD;
        c.useSrcA     = 1'b1;
      end
      OP_STW, OP_STB: begin
        c.memEn       = 1'b1;
        c.memRW       = 1'b1;
        c.SEL_valB    = 1'b1;
        c.SEL_destReg = 1'b1;
        c.alu_op      = ALU_ADD;
        c.useSrcA     = 1'b1;
        c.useSrcB     = 1'b1;
      end
      OP_BNE, OP_BLT, OP_BST: begin
        c.is_branch = 1'b1;
        c.useSrcA   = 1'b1;
        c.useSrcB   = 1'b1;
        c.alu_op    = (opc == OP_BNE) ? ALU_SUB :
                      (opc == OP_BLT) ? ALU_LT  : ALU_AND;
      end
      OP_MOV: begin
        c.regWrEn = 1'b1;
        c.alu_op  = ALU_PASSA;
        c.useSrcA = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic opIllegal(input logic [OPC_W-1:0] opc);
    return opc > OP_NOP;
  endfunction

endpackage

// File: rtl/decode_stage_hazard_scoreboard.sv
// Tracks destination registers of instructions that left decode and flags a
// RAW hazard for the instruction currently offered to decode.
module hazard_scoreboard
  import decode_stage_pkg::*;
#(
  parameter int REG_W      = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int FWD_EN     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pushEn,
  input  logic [REG_W-1:0] pushDest,
  input  logic             pushIsLoad,
  input  logic             candValid,
  input  logic [REG_W-1:0] candDest,
  input  logic             candIsLoad,
  input  logic             useSrcA,
  input  logic [REG_W-1:0] srcA,
  input  logic             useSrcB,
  input  logic [REG_W-1:0] srcB,
  output logic             hazard
);

  logic [PIPE_DEPTH-1:0]            sbValid;
  logic [PIPE_DEPTH-1:0]            sbIsLoad;
  logic [PIPE_DEPTH-1:0][REG_W-1:0] sbDest;

  // With forwarding only a load still sitting in the decode output register
  // can be waited on; R0 is hardwired and never produces a dependency.
  function automatic logic hits(
    input logic             v,
    input logic [REG_W-1:0] d,
    input logic             ld,
    input logic             ua,
    input logic [REG_W-1:0] a,
    input logic             ub,
    input logic [REG_W-1:0] b
  );
    logic match;
    match = (ua && (a == d)) || (ub && (b == d));
    return v && (d != '0) && match && ((FWD_EN != 0) ? ld : 1'b1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbValid  <= '0;
      sbIsLoad <= '0;
      sbDest   <= '0;
    end else begin
      sbValid[0]  <= pushEn;
      sbIsLoad[0] <= pushEn & pushIsLoad;
      sbDest[0]   <= pushDest;
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        sbValid[i]  <= sbValid[i-1];
        sbIsLoad[i] <= sbIsLoad[i-1];
        sbDest[i]   <= sbDest[i-1];
      end
    end
  end

  always_comb begin
    hazard = hits(candValid, candDest, candIsLoad, useSrcA, srcA, useSrcB, srcB);
    if (FWD_EN == 0) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        hazard = hazard | hits(sbValid[i], sbDest[i], sbIsLoad[i],
                               useSrcA, srcA, useSrcB, srcB);
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: decodes one instruction per
// handshake, holds issue on RAW hazards and while a branch is unresolved.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int INSTR_LEN  = 32,
  parameter int PC_W       = 32,
  parameter int NUM_REGS   = 16,
  parameter int PIPE_DEPTH = 3,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_LEN-1:0]         in_instr,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$bits(control_t)-1:0]  out_ctrl,
  output logic [INSTR_LEN-1:0]         out_instr,
  output logic [PC_W-1:0]              out_pc,
  output logic                         out_illegal,
  input  logic                         br_resolve,
  output logic                         hazard_stall,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int REG_W = $clog2(NUM_REGS);

  // Handshake: a word moves on a side in any cycle where valid & ready are both
  // high; valid never depends on ready, and an offered word stays put until taken.
  state_t           state;
  state_t           nextState;
  control_t         inCtrl;
  control_t         ctrlQ;
  logic             inFire;
  logic             outFire;
  logic             hazardRaw;
  logic             hazard;
  logic             outIsLoad;
  logic [REG_W-1:0] inSrcA;
  logic [REG_W-1:0] inSrcB;
  logic [REG_W-1:0] outDest;

  assign inCtrl    = decodeOp(in_instr[OPC_LSB +: OPC_W]);
  assign inSrcA    = in_instr[SRCA_LSB +: REG_W];
  assign inSrcB    = in_instr[SRCB_LSB +: REG_W];
  assign outDest   = out_instr[DEST_LSB +: REG_W];
  assign outIsLoad = ctrlQ.regWrEn & ctrlQ.memEn & ~ctrlQ.memRW;
  assign outFire   = out_valid & out_ready;
  assign inFire    = in_valid & in_ready;
  assign hazard    = in_valid & hazardRaw;
  assign out_ctrl  = ctrlQ;

  hazard_scoreboard #(
    .REG_W      (REG_W),
    .PIPE_DEPTH (PIPE_DEPTH),
    .FWD_EN     (FWD_EN)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .pushEn     (outFire & ctrlQ.regWrEn),
    .pushDest   (outDest),
    .pushIsLoad (outIsLoad),
    .candValid  (out_valid & ctrlQ.regWrEn),
    .candDest   (outDest),
    .candIsLoad (outIsLoad),
    .useSrcA    (inCtrl.useSrcA),
    .srcA       (inSrcA),
    .useSrcB    (inCtrl.useSrcB),
    .srcB       (inSrcB),
    .hazard     (hazardRaw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (outFire && ctrlQ.is_branch) nextState = BR_WAIT;
      BR_WAIT: if (br_resolve) nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    hazard_stall = 1'b0;
    case (state)
      RUN: begin
        in_ready     = ~hazard & (~out_valid | out_ready);
        hazard_stall = hazard;
      end
      default: begin
        in_ready     = 1'b0;
        hazard_stall = 1'b0;
      end
    endcase
  end

  // Output register: payload only changes on accept, so it is stable while blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      ctrlQ       <= '0;
      out_instr   <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else if (inFire) begin
      out_valid   <= 1'b1;
      ctrlQ       <= inCtrl;
      out_instr   <= in_instr;
      out_pc      <= in_pc;
      out_illegal <= opIllegal(in_instr[OPC_LSB +: OPC_W]);
    end else if (outFire) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage, one forwarding and one
// non-forwarding instance, each checked against a cycle-level reference model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int CW    = $bits(control_t);
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]         inValid;
  logic [1:0]         inReady;
  logic [1:0][31:0]   inInstr;
  logic [1:0][31:0]   inPc;
  logic [1:0]         outValid;
  logic [1:0]         outReady;
  logic [1:0][CW-1:0] outCtrl;
  logic [1:0][31:0]   outInstr;
  logic [1:0][31:0]   outPc;
  logic [1:0]         outIllegal;
  logic [1:0]         brResolve;
  logic [1:0]         hazardStall;
  logic [15:0]        stallCnt0;
  logic [3:0]         stallCnt1;

  decode_stage #(.PIPE_DEPTH(DEPTH), .FWD_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_instr(inInstr[0]), .in_pc(inPc[0]), .out_valid(outValid[0]),
    .out_ready(outReady[0]), .out_ctrl(outCtrl[0]), .out_instr(outInstr[0]),
    .out_pc(outPc[0]), .out_illegal(outIllegal[0]), .br_resolve(brResolve[0]),
    .hazard_stall(hazardStall[0]), .stall_cnt(stallCnt0)
  );

  decode_stage #(.PIPE_DEPTH(DEPTH), .FWD_EN(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_instr(inInstr[1]), .in_pc(inPc[1]), .out_valid(outValid[1]),
    .out_ready(outReady[1]), .out_ctrl(outCtrl[1]), .out_instr(outInstr[1]),
    .out_pc(outPc[1]), .out_illegal(outIllegal[1]), .br_resolve(brResolve[1]),
    .hazard_stall(hazardStall[1]), .stall_cnt(stallCnt1)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode table, written from the instruction-set description.
  function automatic control_t refCtrl(input logic [4:0] o);
    control_t c;
    c = '0;
    if (o <= OP_LSR) begin
      c.regWrEn = 1; c.alu_op = o[3:0]; c.useSrcA = 1; c.useSrcB = 1;
    end else if (o == OP_LDW || o == OP_LDB) begin
      c.regWrEn = 1; c.memEn = 1; c.SEL_valB = 1; c.SEL_wrData = 1;
      c.SEL_destReg = 1; c.alu_op = ALU_ADD; c.useSrcA = 1;
    end else if (o == OP_STW || o == OP_STB) begin
      c.memEn = 1; c.memRW = 1; c.SEL_valB = 1; c.SEL_destReg = 1;
      c.alu_op = ALU_ADD; c.useSrcA = 1; c.useSrcB = 1;
    end else if (o == OP_BNE || o == OP_BLT || o == OP_BST) begin
      c.is_branch = 1; c.useSrcA = 1; c.useSrcB = 1;
      c.alu_op = (o == OP_BNE) ? ALU_SUB : (o == OP_BLT) ? ALU_LT : ALU_AND;
    end else if (o == OP_MOV) begin
      c.regWrEn = 1; c.alu_op = ALU_PASSA; c.useSrcA = 1;
    end
    return c;
  endfunction

  function automatic logic [4:0] opcOf(input logic [31:0] i);
    return i[OPC_LSB +: 5];
  endfunction

  function automatic logic [3:0] fld(input logic [31:0] i, input int lsb);
    return i[lsb +: 4];
  endfunction

  function automatic logic [31:0] mkInstr(input logic [4:0] o, input int dst, input int a, input int b);
    logic [31:0] i;
    i = $urandom();
    i[OPC_LSB +: 5]  = o;
    i[DEST_LSB +: 5] = 5'(dst);
    i[SRCA_LSB +: 5] = 5'(a);
    i[SRCB_LSB +: 5] = 5'(b);
    return i;
  endfunction

  // Model state: output slot, branch-wait flag, stall count and, per register,
  // the cycle in which the last writer of that register left decode.
  int          cyc = 0;
  bit   [1:0]  mValid;
  logic [31:0] mInstr [2];
  logic [31:0] mPc    [2];
  bit   [1:0]  mBr;
  int          mStall [2];
  int          lastFire [2][16];
  bit   [1:0]  lastInFire;
  bit   [1:0]  expReady;
  bit   [1:0]  expStall;

  function automatic bit regBusy(input int d, input logic [3:0] r);
    logic [4:0] o;
    bit fwd;
    fwd = (d == 0);
    o   = opcOf(mInstr[d]);
    if (r == 0) return 0;
    if (mValid[d] && refCtrl(o).regWrEn && fld(mInstr[d], DEST_LSB) == r &&
        (!fwd || o == OP_LDW || o == OP_LDB)) return 1;
    if (!fwd && (cyc - lastFire[d][r] <= DEPTH)) return 1;
    return 0;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mValid[d] = 0; mBr[d] = 0; mStall[d] = 0; lastInFire[d] = 0;
      for (int r = 0; r < 16; r++) lastFire[d][r] = -100;
    end
  endtask

  task automatic evalAndCheck(input int d);
    logic [4:0] o;
    control_t   c;
    bit         haz;
    logic [15:0] cnt;
    o   = opcOf(inInstr[d]);
    c   = refCtrl(o);
    haz = inValid[d] && ((c.useSrcA && regBusy(d, fld(inInstr[d], SRCA_LSB))) ||
                         (c.useSrcB && regBusy(d, fld(inInstr[d], SRCB_LSB))));
    expStall[d] = haz && !mBr[d];
    expReady[d] = !mBr[d] && !haz && (!mValid[d] || outReady[d]);
    cnt = (d == 0) ? stallCnt0 : {12'b0, stallCnt1};
    checkVal($sformatf("d%0d.in_ready", d), inReady[d], expReady[d]);
    checkVal($sformatf("d%0d.hazard_stall", d), hazardStall[d], expStall[d]);
    checkVal($sformatf("d%0d.out_valid", d), outValid[d], mValid[d]);
    checkVal($sformatf("d%0d.stall_cnt", d), cnt, mStall[d]);
    if (mValid[d]) begin
      checkVal($sformatf("d%0d.out_instr", d), outInstr[d], mInstr[d]);
      checkVal($sformatf("d%0d.out_pc", d), outPc[d], mPc[d]);
      checkVal($sformatf("d%0d.out_ctrl", d), outCtrl[d], refCtrl(opcOf(mInstr[d])));
      checkVal($sformatf("d%0d.out_illegal", d), outIllegal[d], opcOf(mInstr[d]) > OP_NOP);
    end
  endtask

  task automatic modelAdvance(input int d);
    bit of, inf;
    logic [4:0] o;
    of = mValid[d] && outReady[d];
    inf = inValid[d] && expReady[d];
    o  = opcOf(mInstr[d]);
    if (of && refCtrl(o).regWrEn) lastFire[d][fld(mInstr[d], DEST_LSB)] = cyc;
    if (!mBr[d] && of && refCtrl(o).is_branch) mBr[d] = 1;
    else if (mBr[d] && brResolve[d]) mBr[d] = 0;
    if (expStall[d] && mStall[d] < ((d == 0) ? 65535 : 15)) mStall[d]++;
    if (inf) begin
      mValid[d] = 1; mInstr[d] = inInstr[d]; mPc[d] = inPc[d];
    end else if (of) begin
      mValid[d] = 0;
    end
    lastInFire[d] = inf;
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    #1;
    for (int d = 0; d < 2; d++) evalAndCheck(d);
    for (int d = 0; d < 2; d++) modelAdvance(d);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    inValid = '0; outReady = '1; brResolve = '0;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkVal($sformatf("d%0d.rst_out_valid", d), outValid[d], 0);
      checkVal($sformatf("d%0d.rst_out_ctrl", d), outCtrl[d], 0);
      checkVal($sformatf("d%0d.rst_out_instr", d), outInstr[d], 0);
      checkVal($sformatf("d%0d.rst_out_pc", d), outPc[d], 0);
      checkVal($sformatf("d%0d.rst_out_illegal", d), outIllegal[d], 0);
    end
    checkVal("d0.rst_stall_cnt", stallCnt0, 0);
    checkVal("d1.rst_stall_cnt", stallCnt1, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sendInstr(input int d, input logic [31:0] ins, output int waited);
    inValid[d] = 1; inInstr[d] = ins; inPc[d] = $urandom();
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!lastInFire[d] && waited < 50);
    if (!lastInFire[d]) checkVal($sformatf("d%0d.send_timeout", d), 0, 1);
    inValid[d] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit [1:0] pending;
    rst_n = 1'b0;
    idle();
    inInstr = '0; inPc = '0;
    @(negedge clk);
    doReset();

    // Forwarding: ALU result consumed immediately issues back to back.
    sendInstr(0, mkInstr(OP_ADD, 3, 1, 2), w);
    checkVal("t1_first_accept", w, 1);
    outReady[0] = 1;
    sendInstr(0, mkInstr(OP_ADD, 4, 3, 3), w);
    checkVal("t1_b2b_accept", w, 1);
    drain(4);
    checkVal("t1_stall_cnt", stallCnt0, 0);

    // Forwarding: load-use costs exactly one cycle.
    doReset();
    sendInstr(0, mkInstr(OP_LDW, 3, 1, 0), w);
    sendInstr(0, mkInstr(OP_ADD, 4, 3, 1), w);
    checkVal("t2_wait", w, 2);
    drain(3);
    checkVal("t2_stall_cnt", stallCnt0, 1);

    // No forwarding: consumer waits out output register plus every scoreboard entry.
    doReset();
    sendInstr(1, mkInstr(OP_ADD, 3, 1, 2), w);
    sendInstr(1, mkInstr(OP_ADD, 5, 3, 1), w);
    checkVal("t3_wait", w, 5);
    drain(4);
    checkVal("t3_stall_cnt", stallCnt1, 4);
    doReset();
    sendInstr(1, mkInstr(OP_ADD, 0, 1, 2), w);
    sendInstr(1, mkInstr(OP_ADD, 5, 0, 0), w);
    drain(4);
    checkVal("t3_r0_stall_cnt", stallCnt1, 0);

    // Branch hold and release.
    doReset();
    sendInstr(0, mkInstr(OP_BNE, 0, 1, 2), w);
    tick();
    inValid[0] = 1; inInstr[0] = mkInstr(OP_ADD, 7, 1, 1); inPc[0] = 32'h100;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkVal($sformatf("t4_hold_%0d", k), inReady[0], 0);
      tick();
    end
    brResolve[0] = 1;
    tick();
    brResolve[0] = 0;
    #1;
    checkVal("t4_release", inReady[0], 1);
    tick();
    drain(3);

    // Backpressure keeps the output word stable; illegal opcode decodes to zero.
    doReset();
    outReady[0] = 0;
    sendInstr(0, mkInstr(OP_STW, 2, 3, 4), w);
    inValid[0] = 1; inInstr[0] = mkInstr(OP_MOV, 6, 2, 0); inPc[0] = 32'h200;
    repeat (3) tick();
    #1;
    checkVal("t5_backpressure_ready", inReady[0], 0);
    outReady[0] = 1;
    tick();
    inValid[0] = 0;
    tick();
    sendInstr(0, mkInstr(5'd31, 3, 1, 2), w);
    #1;
    checkVal("t5_illegal_flag", outIllegal[0], 1);
    checkVal("t5_illegal_ctrl", outCtrl[0], 0);
    drain(3);

    // Reset while a load sits in the output register.
    doReset();
    for (int k = 0; k < 7; k++) begin
      sendInstr(0, mkInstr(OP_LDW, 3, 1, 0), w);
      sendInstr(0, mkInstr(OP_ADD, 4, 3, 1), w);
    end
    drain(2);
    checkVal("t6_stall_cnt", stallCnt0, 7);
    outReady[0] = 0;
    sendInstr(0, mkInstr(OP_LDW, 5, 1, 0), w);
    doReset();
    idle();
    inValid[0] = 1; inInstr[0] = mkInstr(OP_ADD, 6, 5, 5); inPc[0] = 32'h300;
    #1;
    checkVal("t6_no_stall", hazardStall[0], 0);
    checkVal("t6_ready", inReady[0], 1);
    tick();
    drain(3);

    // Random traffic on both instances.
    pending = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (!pending[d]) begin
          inValid[d] = ($urandom_range(0, 9) < 7);
          inInstr[d] = mkInstr(($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31))
                                                          : 5'($urandom_range(0, 16)),
                               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
          inPc[d] = $urandom();
        end
        outReady[d]  = ($urandom_range(0, 3) != 0);
        brResolve[d] = ($urandom_range(0, 5) == 0);
      end
      tick();
      for (int d = 0; d < 2; d++) pending[d] = inValid[d] && !lastInFire[d];
    end
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
